// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with optional 2-entry skid, flush and stall counter
module pipe_stage_elastic #(
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 128,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, pop;
  always_comb begin
    out_valid    = main_valid_q;
    out_ctrl     = main_ctrl_q & {CTRL_W{main_valid_q}};
    out_data     = main_data_q;
    occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    stall_cnt    = stall_cnt_q;
    pop          = main_valid_q & out_ready;
    in_ready     = (SKID_EN != 0) ? rdy_q : rdy_q & (!main_valid_q | out_ready);
    accept       = in_valid & in_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (SKID_EN != 0) begin
      if (!main_valid_q || pop) begin
        if (skid_valid_q) begin
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = accept;
          main_ctrl_d  = accept ? in_ctrl : main_ctrl_q;
          main_data_d  = accept ? in_data : main_data_q;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end else begin
      main_valid_d = accept | (main_valid_q & !pop);
      main_ctrl_d  = accept ? in_ctrl : main_ctrl_q;
      main_data_d  = accept ? in_data : main_data_q;
    end
    // flush squashes entries and control but leaves data payloads in place
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
    end
    rdy_d       = (SKID_EN != 0) ? !skid_valid_d : 1'b1;
    stall_cnt_d = (main_valid_q && !out_ready && stall_cnt_q != {CNT_W{1'b1}}) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      rdy_q        <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      rdy_q        <= rdy_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end
endmodule
